// File: rtl/ifetch_queue_if.sv
// Bundle of the fetch-side memory bus, redirect strobe and decoded-stream handshake.
// master is the fetch queue side; slave is the memory/branch-unit/consumer side.
interface ifetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, one-cycle memory, redirect flush.
// Define IFETCH_QUEUE_PERF_EN to add fetch/discard/stall performance counters.
module ifetch_queue #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
    ifetch_queue_if.master bus
`ifdef IFETCH_QUEUE_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] discard_count,
    output logic [31:0] stall_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic              inflight_reg;
    logic              discard_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  occupancy;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic              flush, issue, push, pop;

    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    // Credits count both stored entries and the word still on its way back,
    // so a push can never land in a full queue.
    assign occupancy = count_reg + CNT_W'(inflight_reg);
    assign flush     = bus.redirect_valid;
    assign issue     = (occupancy < CNT_W'(DEPTH)) && !flush && !rst;
    assign push      = inflight_reg && !discard_reg && !flush;
    assign pop       = bus.out_valid && bus.out_ready && !flush;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_reg & WORD_MASK;

    // Head is gated so the outputs read zero whenever the queue is empty.
    assign bus.out_valid = (count_reg != '0);
    assign bus.out_inst  = bus.out_valid ? inst_mem[rd_ptr_reg] : '0;
    assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr_reg]   : '0;

    always_comb begin
        count_next    = count_reg;
        fetch_pc_next = fetch_pc_reg;
        if (flush) begin
            count_next    = '0;
            fetch_pc_next = bus.redirect_pc & WORD_MASK;
        end else begin
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
            if (issue) begin
                fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            discard_reg     <= 1'b0;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_pc_reg <= bus.imem_addr;
            inflight_reg    <= issue;
            discard_reg     <= flush;
            count_reg       <= count_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Storage carries no reset; the gated head hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= bus.imem_rdata;
            pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
        end
    end

`ifdef IFETCH_QUEUE_PERF_EN
    logic drop;
    assign drop = inflight_reg && (discard_reg || flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count   <= '0;
            discard_count <= '0;
            stall_count   <= '0;
        end else begin
            fetch_count   <= fetch_count + 32'(push);
            discard_count <= discard_count + 32'(drop)
                           + (flush ? 32'(count_reg) : 32'd0);
            stall_count   <= stall_count + 32'(bus.out_valid && !bus.out_ready);
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: sequential fetch, full-queue credit stall, redirects, mid-stream reset.
module tb_ifetch_queue;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef IFETCH_QUEUE_PERF_EN
    logic [31:0] fetch_count, discard_count, stall_count;
`endif

    ifetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef IFETCH_QUEUE_PERF_EN
        ,
        .fetch_count(fetch_count),
        .discard_count(discard_count),
        .stall_count(stall_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    // One-cycle instruction memory
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? word(bus.imem_addr) : 32'h0BAD_BEEF;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("check %s ok (0x%0h)", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = rdy;
        cyc();
        #1;
        check_eq("rst_req",   64'(bus.imem_req),  64'd0);
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_inst",  64'(bus.out_inst),  64'd0);
        check_eq("rst_pc",    64'(bus.out_pc),    64'd0);
        cyc();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int n16, others, bad;
        logic [31:0] e;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b1;

        // Sequential fetch with consumer always ready
        do_reset(1'b1);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin cyc(); #1; end
            check_eq("seq_req",  64'(bus.imem_req),  64'd1);
            check_eq("seq_addr", 64'(bus.imem_addr), 64'(4 * k));
            if (k < 2) begin
                check_eq("seq_valid0", 64'(bus.out_valid), 64'd0);
            end else begin
                e = 32'(4 * (k - 2));
                check_eq("seq_valid", 64'(bus.out_valid), 64'd1);
                check_eq("seq_pc",    64'(bus.out_pc),    64'(e));
                check_eq("seq_inst",  64'(bus.out_inst),  64'(word(e)));
            end
        end

        // Consumer stalled: exactly DEPTH requests, head holds pc 0
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin cyc(); #1; end
            if (k < 4) begin
                check_eq("full_req",  64'(bus.imem_req),  64'd1);
                check_eq("full_addr", 64'(bus.imem_addr), 64'(4 * k));
            end else begin
                check_eq("full_noreq", 64'(bus.imem_req), 64'd0);
            end
            if (k >= 2) begin
                check_eq("full_pc",   64'(bus.out_pc),   64'd0);
                check_eq("full_inst", 64'(bus.out_inst), 64'(word(32'h0)));
            end
        end
`ifdef IFETCH_QUEUE_PERF_EN
        check_eq("perf_fetch4", 64'(fetch_count), 64'd4);
`endif

        // Single-cycle pop from a full queue frees exactly one credit
        cyc();
        bus.out_ready = 1'b1;
        #1;
        check_eq("pop_head", 64'(bus.out_pc), 64'd0);
        n16 = 0;
        others = 0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                cyc();
                if (j == 1) bus.out_ready = 1'b0;
                #1;
                check_eq("pop_newhead", 64'(bus.out_pc), 64'd4);
            end
            if (bus.imem_req) begin
                if (bus.imem_addr == 32'd16) n16++;
                else others++;
            end
        end
        check_eq("pop_req16",  64'(n16),    64'd1);
        check_eq("pop_others", 64'(others), 64'd0);
        cyc();
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin cyc(); #1; end
            check_eq("drain_valid", 64'(bus.out_valid), 64'd1);
            check_eq("drain_pc",    64'(bus.out_pc),    64'(4 + 4 * i));
        end

        // Redirect while the 0x8 fetch is in flight
        do_reset(1'b1);
        cyc(); #1;
        cyc(); #1;
        check_eq("redir_pre_addr", 64'(bus.imem_addr), 64'h8);
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h103;
        #1;
        check_eq("redir_noreq", 64'(bus.imem_req), 64'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("redir_req",    64'(bus.imem_req),  64'd1);
        check_eq("redir_addr",   64'(bus.imem_addr), 64'h100);
        check_eq("redir_empty",  64'(bus.out_valid), 64'd0);
`ifdef IFETCH_QUEUE_PERF_EN
        check_eq("perf_discard", 64'(discard_count), 64'd2);
`endif
        cyc(); #1;
        check_eq("redir_empty2", 64'(bus.out_valid), 64'd0);
        check_eq("redir_addr2",  64'(bus.imem_addr), 64'h104);
        cyc(); #1;
        check_eq("redir_valid",  64'(bus.out_valid), 64'd1);
        check_eq("redir_pc",     64'(bus.out_pc),    64'h100);
        check_eq("redir_inst",   64'(bus.out_inst),  64'(word(32'h100)));

        // Back-to-back redirects: last target wins
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        #1;
        check_eq("b2b_noreq1", 64'(bus.imem_req), 64'd0);
        cyc();
        bus.redirect_pc = 32'h80;
        #1;
        check_eq("b2b_noreq2", 64'(bus.imem_req), 64'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("b2b_addr",  64'(bus.imem_addr), 64'h80);
        check_eq("b2b_req",   64'(bus.imem_req),  64'd1);
        check_eq("b2b_empty", 64'(bus.out_valid), 64'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(); #1;
            if (bus.out_valid && bus.out_pc >= 32'h40 && bus.out_pc < 32'h80) bad++;
            if (i == 1) check_eq("b2b_first_pc", 64'(bus.out_pc), 64'h80);
        end
        check_eq("b2b_no_stale", 64'(bad), 64'd0);

        // One-cycle reset in the middle of the stream
        cyc(); #1;
        cyc();
        rst = 1'b1;
        #1;
        check_eq("mrst_noreq", 64'(bus.imem_req), 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        check_eq("mrst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mrst_req",   64'(bus.imem_req),  64'd1);
        check_eq("mrst_addr",  64'(bus.imem_addr), 64'h0);
`ifdef IFETCH_QUEUE_PERF_EN
        check_eq("mrst_fetch",   64'(fetch_count),   64'd0);
        check_eq("mrst_discard", 64'(discard_count), 64'd0);
        check_eq("mrst_stall",   64'(stall_count),   64'd0);
`endif
        cyc(); #1;
        check_eq("mrst_valid2", 64'(bus.out_valid), 64'd0);
        check_eq("mrst_addr2",  64'(bus.imem_addr), 64'h4);
        cyc(); #1;
        check_eq("mrst_valid3", 64'(bus.out_valid), 64'd1);
        check_eq("mrst_pc",     64'(bus.out_pc),    64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
